ttd_multichannel: RTL and testbench
===================================

Name: ttd_multichannel

Overview:
Parametrised time-to-digital converter for the temperature-sensor front end. It discharges a sensing capacitor (rst_cap), counts clk cycles until the comparator output (in) rises, and averages 2^AVG_LOG2 conversions per channel. It scans N_CH channels round-robin through an external analog mux (ch_sel) and presents one averaged result per channel with a valid pulse, channel tag and overflow flag. It replaces the single-channel, single-shot TTD.

Parameters:
TIMER_BITS, 8, result width; internal counter is TIMER_BITS+1 bits
N_CH, 2, number of channels scanned; N_CH >= 1
AVG_LOG2, 2, log2 of conversions averaged per result (0 = no averaging)
RST_CYCLES, 4, minimum cycles rst_cap is held high per conversion; >= 1

Ports:
clk  in  1  system clock (40 MHz nominal)
rst  in  1  asynchronous, active-high reset
en  in  1  level: run continuous scanning while high
in  in  1  comparator output of the selected channel; asynchronous to clk
rst_cap  out  1  high = capacitor held discharged
ch_sel  out  max(1,$clog2(N_CH))  analog mux select
busy  out  1  high whenever the FSM is not in IDLE
data_out  out  TIMER_BITS  averaged result
data_ch  out  max(1,$clog2(N_CH))  channel of data_out
data_valid  out  1  one-cycle pulse: data_out, data_ch and overflow are updated
overflow  out  1  at least one conversion in this result timed out

Behaviour:
- Reset (asynchronous, rst=1): FSM=IDLE, rst_cap=1, ch_sel=0, busy=0, data_out=0, data_ch=0, data_valid=0, overflow=0, accumulator=0, counters=0, synchroniser flops=0. Reset mid-conversion aborts the conversion with no output.
- in passes through a 2-flop synchroniser (in_s) before use.
- FSM states: IDLE, DISCHARGE, CHARGE, ACCUM, REPORT.
- IDLE: rst_cap=1. If en=1, go to DISCHARGE on the next edge with ch_sel=0, sample index=0, acc=0.
- DISCHARGE: rst_cap=1, discharge counter counts up. Exit to CHARGE once the counter has reached RST_CYCLES-1 and in_s=0. A stuck-high comparator holds the FSM in DISCHARGE indefinitely.
- CHARGE: rst_cap=0.
  - cnt (TIMER_BITS+1 bits) is 0 in the first CHARGE cycle and increments by 1 each cycle.
  - On the first cycle with in_s=1: sample=cnt, go to ACCUM.
  - Timeout: when cnt reaches 2^TIMER_BITS, set sample=2^TIMER_BITS-1, set the sticky ovf for this result, go to ACCUM.
  - sample is therefore always <= 2^TIMER_BITS-1.
- ACCUM (1 cycle): rst_cap=1, acc += sample. acc is TIMER_BITS+AVG_LOG2 bits and cannot overflow.
  - If sample index < 2^AVG_LOG2-1: index++, go to DISCHARGE.
  - Otherwise go to REPORT.
- REPORT (1 cycle): data_out=acc>>AVG_LOG2 (truncating), data_ch=ch_sel, overflow=ovf, data_valid=1 for this cycle only.
  - Then clear acc, ovf and index, and advance ch_sel (N_CH-1 wraps to 0).
  - If en=1, go to DISCHARGE; otherwise go to IDLE with ch_sel=0.
- ch_sel changes only on the REPORT exit, while rst_cap=1, so the mux always settles during discharge.
- en is sampled only in IDLE and REPORT. Deasserting en mid-result completes the current channel's result.
- data_out, data_ch and overflow hold their values between data_valid pulses.
- Latency: with in driven synchronously and first high at the edge after cnt==C, sample = C+2 (synchroniser delay).

Decomposition:
- Package ttd_pkg:
  - state enum typedef (IDLE, DISCHARGE, CHARGE, ACCUM, REPORT)
  - CH_W = max(1,$clog2(N_CH)) helper function
  - default parameter constants
- Sub-module ttd_sync: 2-flop synchroniser with async reset; parameter-free, 1-bit.
- Counter, accumulator and FSM stay in ttd_multichannel.

Test Plan:
1. Defaults, AVG_LOG2=0. Release rst, en=1, assert in at the edge after cnt==128 (~3.26 us) -> data_valid pulse with data_out=130, data_ch=0, overflow=0; rst_cap was high for 4 cycles before the count.
2. AVG_LOG2=2. Charge counts yield samples 100, 101, 102, 104 -> a single data_valid with data_out=101 (407>>2), after 4 discharge/charge cycles.
3. Timeout: in never rises -> rst_cap low for 256 cycles; sample=255, overflow=1, data_out=255. The next result with a valid in gives overflow=0.
4. N_CH=3, en held high -> results arrive with data_ch sequence 0, 1, 2, 0. ch_sel only changes while rst_cap=1.
5. in held high during DISCHARGE -> FSM stays in DISCHARGE with rst_cap=1. Release in -> CHARGE begins 3 cycles later (2 synchroniser + 1 registration edges).
6. Boundary cases:
   - Assert rst mid-CHARGE -> all outputs return to reset values immediately and no data_valid occurs.
   - Drop en mid-average -> the current result completes, then IDLE with busy=0 and ch_sel=0.

Source files
------------

// File: rtl/ttd_pkg.sv
// Shared types and defaults for the multichannel time-to-digital converter.
package ttd_pkg;

    localparam int unsigned TIMER_BITS_DEF = 8;
    localparam int unsigned N_CH_DEF       = 2;
    localparam int unsigned AVG_LOG2_DEF   = 2;
    localparam int unsigned RST_CYCLES_DEF = 4;

    typedef enum logic [2:0] {
        StIdle,
        StDischarge,
        StCharge,
        StAccum,
        StReport
    } ttd_state_e;

    function automatic int unsigned ch_w(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/ttd_sync.sv
// Two-flop synchroniser for the asynchronous comparator output.
module ttd_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ttd_multichannel.sv
// Round-robin multichannel TDC: discharge, count until the comparator trips, average, report.
module ttd_multichannel
    import ttd_pkg::*;
#(
    parameter int unsigned TIMER_BITS = TIMER_BITS_DEF,
    parameter int unsigned N_CH       = N_CH_DEF,
    parameter int unsigned AVG_LOG2   = AVG_LOG2_DEF,
    parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in,
    output logic                  rst_cap,
    output logic [ch_w(N_CH)-1:0] ch_sel,
    output logic                  busy,
    output logic [TIMER_BITS-1:0] data_out,
    output logic [ch_w(N_CH)-1:0] data_ch,
    output logic                  data_valid,
    output logic                  overflow
);

    localparam int unsigned CH_W  = ch_w(N_CH);
    localparam int unsigned ACC_W = TIMER_BITS + AVG_LOG2;
    localparam int unsigned IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned DIS_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [DIS_W-1:0]      DIS_LAST   = DIS_W'(RST_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [CH_W-1:0]       CH_LAST    = CH_W'(N_CH - 1);
    localparam logic [TIMER_BITS:0]   CNT_TMO    = {1'b1, {TIMER_BITS{1'b0}}};
    localparam logic [TIMER_BITS-1:0] SAMPLE_MAX = '1;

    ttd_state_e            state_q;
    logic                  in_s;
    logic [DIS_W-1:0]      dis_cnt_q;
    logic [TIMER_BITS:0]   cnt_q;
    logic [TIMER_BITS:0]   cnt_d;
    logic [TIMER_BITS-1:0] sample_q;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      acc_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  ovf_q;
    logic                  rst_cap_q;
    logic [CH_W-1:0]       ch_sel_q;
    logic [TIMER_BITS-1:0] data_out_q;
    logic [CH_W-1:0]       data_ch_q;
    logic                  data_valid_q;
    logic                  overflow_q;

    ttd_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (in),
        .q_o (in_s)
    );

    assign cnt_d = cnt_q + (TIMER_BITS + 1)'(1);
    assign acc_d = acc_q + ACC_W'(sample_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            dis_cnt_q    <= '0;
            cnt_q        <= '0;
            sample_q     <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            ovf_q        <= 1'b0;
            rst_cap_q    <= 1'b1;
            ch_sel_q     <= '0;
            data_out_q   <= '0;
            data_ch_q    <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    rst_cap_q <= 1'b1;
                    if (en) begin
                        state_q   <= StDischarge;
                        ch_sel_q  <= '0;
                        idx_q     <= '0;
                        acc_q     <= '0;
                        ovf_q     <= 1'b0;
                        dis_cnt_q <= '0;
                    end
                end
                StDischarge: begin
                    if (dis_cnt_q != DIS_LAST) begin
                        dis_cnt_q <= dis_cnt_q + DIS_W'(1);
                    end else if (!in_s) begin
                        state_q   <= StCharge;
                        rst_cap_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                StCharge: begin
                    cnt_q <= cnt_d;
                    // A trip on the last countable cycle still yields a valid, non-overflow sample.
                    if (in_s || cnt_d == CNT_TMO) begin
                        state_q   <= StAccum;
                        rst_cap_q <= 1'b1;
                        sample_q  <= in_s ? cnt_q[TIMER_BITS-1:0] : SAMPLE_MAX;
                        if (!in_s) begin
                            ovf_q <= 1'b1;
                        end
                    end
                end
                StAccum: begin
                    acc_q     <= acc_d;
                    dis_cnt_q <= '0;
                    if (idx_q != IDX_LAST) begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= StDischarge;
                    end else begin
                        // Results are loaded here so they are visible during the REPORT cycle.
                        state_q      <= StReport;
                        data_out_q   <= TIMER_BITS'(acc_d >> AVG_LOG2);
                        data_ch_q    <= ch_sel_q;
                        overflow_q   <= ovf_q;
                        data_valid_q <= 1'b1;
                    end
                end
                StReport: begin
                    acc_q     <= '0;
                    ovf_q     <= 1'b0;
                    idx_q     <= '0;
                    dis_cnt_q <= '0;
                    if (en) begin
                        state_q  <= StDischarge;
                        ch_sel_q <= (ch_sel_q == CH_LAST) ? '0 : ch_sel_q + CH_W'(1);
                    end else begin
                        state_q  <= StIdle;
                        ch_sel_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rst_cap    = rst_cap_q;
    assign ch_sel     = ch_sel_q;
    assign busy       = (state_q != StIdle);
    assign data_out   = data_out_q;
    assign data_ch    = data_ch_q;
    assign data_valid = data_valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ttd_multichannel.sv
// Directed bench: dut_a runs single-shot conversions, dut_b runs 4x averaging over 3 channels.
`timescale 1ns / 1ps
module tb_ttd_multichannel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_a = 1'b0;
    logic       in_a = 1'b0;
    logic       en_b = 1'b0;
    logic       in_b = 1'b0;

    logic       rst_cap_a, busy_a, data_valid_a, overflow_a;
    logic [0:0] ch_sel_a, data_ch_a;
    logic [7:0] data_out_a;
    logic       rst_cap_b, busy_b, data_valid_b, overflow_b;
    logic [1:0] ch_sel_b, data_ch_b;
    logic [7:0] data_out_b;

    int checks = 0;
    int errors = 0;
    int ch_viol = 0;
    int dv_cnt_b = 0;
    logic [0:0] ch_prev_a = '0;
    logic [1:0] ch_prev_b = '0;

    ttd_multichannel #(
        .TIMER_BITS (8),
        .N_CH       (2),
        .AVG_LOG2   (0),
        .RST_CYCLES (4)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en_a),
        .in         (in_a),
        .rst_cap    (rst_cap_a),
        .ch_sel     (ch_sel_a),
        .busy       (busy_a),
        .data_out   (data_out_a),
        .data_ch    (data_ch_a),
        .data_valid (data_valid_a),
        .overflow   (overflow_a)
    );

    ttd_multichannel #(
        .TIMER_BITS (8),
        .N_CH       (3),
        .AVG_LOG2   (2),
        .RST_CYCLES (4)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en_b),
        .in         (in_b),
        .rst_cap    (rst_cap_b),
        .ch_sel     (ch_sel_b),
        .busy       (busy_b),
        .data_out   (data_out_b),
        .data_ch    (data_ch_b),
        .data_valid (data_valid_b),
        .overflow   (overflow_b)
    );

    always #10 clk = ~clk;

    // The mux select may only move while the capacitor is held discharged.
    always @(negedge clk) begin
        if (!rst) begin
            if (ch_sel_a != ch_prev_a && rst_cap_a !== 1'b1) ch_viol <= ch_viol + 1;
            if (ch_sel_b != ch_prev_b && rst_cap_b !== 1'b1) ch_viol <= ch_viol + 1;
            if (data_valid_b === 1'b1) dv_cnt_b <= dv_cnt_b + 1;
        end
        ch_prev_a <= ch_sel_a;
        ch_prev_b <= ch_sel_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_dv(input bit sel_b);
        int k = 0;
        while ((sel_b ? data_valid_b : data_valid_a) !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("data_valid_within_bound", 32'(k < 1000), 1);
    endtask

    // Raises in_a at the end of the cnt==c cycle, then waits for the result.
    task automatic conv_a(input int c);
        int k = 0;
        while (rst_cap_a !== 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("a_charge_start", 32'(k < 1000), 1);
        repeat (c) @(negedge clk);
        in_a = 1'b1;
        wait_dv(1'b0);
        in_a = 1'b0;
    endtask

    // Single conversion on dut_b; returns at the ACCUM cycle.
    task automatic conv_b(input int c);
        int k = 0;
        while (rst_cap_b !== 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("b_charge_start", 32'(k < 1000), 1);
        repeat (c) @(negedge clk);
        in_b = 1'b1;
        k = 0;
        while (rst_cap_b !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("b_charge_end", 32'(k < 1000), 1);
        in_b = 1'b0;
    endtask

    initial begin
        int n;
        int k;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rst_cap", 32'(rst_cap_a), 1);
        chk("rst_ch_sel", 32'(ch_sel_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_data_out", 32'(data_out_a), 0);
        chk("rst_data_ch", 32'(data_ch_a), 0);
        chk("rst_data_valid", 32'(data_valid_a), 0);
        chk("rst_overflow", 32'(overflow_a), 0);
        chk("rst_b_rst_cap", 32'(rst_cap_b), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy_en0", 32'(busy_a), 0);

        // dut_b: averaged results on channels 0, 1, 2, then 0 with en dropped mid-average
        en_b = 1'b1;
        conv_b(98); conv_b(99); conv_b(100); conv_b(102);
        wait_dv(1'b1);
        chk("avg_ch0_data", 32'(data_out_b), 101);
        chk("avg_ch0_tag", 32'(data_ch_b), 0);
        chk("avg_ch0_ovf", 32'(overflow_b), 0);
        chk("avg_single_pulse", 32'(dv_cnt_b), 0);
        @(negedge clk);
        chk("avg_dv_one_cycle", 32'(data_valid_b), 0);
        chk("avg_data_held", 32'(data_out_b), 101);
        conv_b(48); conv_b(48); conv_b(48); conv_b(49);
        wait_dv(1'b1);
        chk("avg_ch1_data", 32'(data_out_b), 50);
        chk("avg_ch1_tag", 32'(data_ch_b), 1);
        conv_b(8); conv_b(18); conv_b(28); conv_b(38);
        wait_dv(1'b1);
        chk("avg_ch2_data", 32'(data_out_b), 25);
        chk("avg_ch2_tag", 32'(data_ch_b), 2);
        conv_b(3);
        en_b = 1'b0;
        conv_b(4); conv_b(5); conv_b(7);
        wait_dv(1'b1);
        chk("en_drop_data_trunc", 32'(data_out_b), 6);
        chk("en_drop_tag_wrap", 32'(data_ch_b), 0);
        @(negedge clk);
        chk("en_drop_busy", 32'(busy_b), 0);
        chk("en_drop_ch_sel", 32'(ch_sel_b), 0);
        chk("en_drop_rst_cap", 32'(rst_cap_b), 1);
        repeat (20) @(negedge clk);
        chk("en_drop_stays_idle", 32'(busy_b), 0);
        chk("b_result_count", 32'(dv_cnt_b), 4);

        // dut_a: single-shot latency and discharge length
        en_a = 1'b1;
        n = 0;
        k = 0;
        while (rst_cap_a !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
            if (busy_a === 1'b1 && rst_cap_a === 1'b1) n++;
        end
        chk("discharge_cycles", 32'(n), 4);
        conv_a(128);
        chk("single_data", 32'(data_out_a), 130);
        chk("single_tag", 32'(data_ch_a), 0);
        chk("single_ovf", 32'(overflow_a), 0);
        conv_a(10);
        chk("ch1_data", 32'(data_out_a), 12);
        chk("ch1_tag", 32'(data_ch_a), 1);

        // Timeout: comparator never trips
        k = 0;
        while (rst_cap_a !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n = 0;
        while (rst_cap_a === 1'b0 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_charge_cycles", 32'(n), 256);
        wait_dv(1'b0);
        chk("tmo_data", 32'(data_out_a), 255);
        chk("tmo_ovf", 32'(overflow_a), 1);
        chk("tmo_tag", 32'(data_ch_a), 0);
        conv_a(0);
        chk("post_tmo_data", 32'(data_out_a), 2);
        chk("post_tmo_ovf_clear", 32'(overflow_a), 0);
        conv_a(200);
        chk("c200_data", 32'(data_out_a), 202);

        // Stuck-high comparator holds DISCHARGE
        in_a = 1'b1;
        repeat (30) @(negedge clk);
        chk("stuck_rst_cap", 32'(rst_cap_a), 1);
        chk("stuck_busy", 32'(busy_a), 1);
        in_a = 1'b0;
        @(negedge clk);
        chk("release_plus1", 32'(rst_cap_a), 1);
        @(negedge clk);
        chk("release_plus2", 32'(rst_cap_a), 1);
        @(negedge clk);
        chk("release_plus3_charge", 32'(rst_cap_a), 0);
        chk("pre_rst_ch_sel", 32'(ch_sel_a), 1);

        // Reset mid-CHARGE
        repeat (50) @(negedge clk);
        en_a = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_rst_cap", 32'(rst_cap_a), 1);
        chk("midrst_busy", 32'(busy_a), 0);
        chk("midrst_ch_sel", 32'(ch_sel_a), 0);
        chk("midrst_data_out", 32'(data_out_a), 0);
        chk("midrst_overflow", 32'(overflow_a), 0);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (data_valid_a !== 1'b0) n++;
        end
        rst = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (data_valid_a !== 1'b0) n++;
        end
        chk("midrst_no_valid", 32'(n), 0);
        chk("midrst_stays_idle", 32'(busy_a), 0);

        chk("ch_sel_only_during_discharge", 32'(ch_viol), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
